// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle between the frame arbiter, its two clients and the memory port.
interface frame_mem_arbiter_if;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // Arbiter side: takes client requests, drives the memory port.
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rdata_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    output wr_ready, rd_ready, rdata_valid, rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Client and memory side.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rdata_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    input  wr_ready, rd_ready, rdata_valid, rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Round-robin arbiter between a pixel writer and a frame reader sharing one
// memory port, with address checking and a small read-return FIFO.
module frame_mem_arbiter #(
  parameter int unsigned FRAME_SIZE_BYTES = 3_686_400,
  parameter int unsigned NUM_BUFS         = 4,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  frame_mem_arbiter_if.slave bus,
  input  logic               err_clr,
  output logic               err_addr
);

  localparam logic [31:0] ADDR_LIMIT = 32'(NUM_BUFS * FRAME_SIZE_BYTES);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2} state_e;
  typedef enum logic {PRIO_WR = 1'b0, PRIO_RD = 1'b1} prio_e;

  state_e        state_q, state_d;
  prio_e         prio_q, prio_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [31:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          in_idle, has_space, rd_ok, wr_rdy, rd_rdy;
  logic          wr_hs, rd_hs, illegal, push, pop;
  logic [31:0]   req_addr;

  // Arbitration: the loser of a simultaneous request sees ready low.
  always_comb begin
    in_idle   = rst_n && (state_q == IDLE);
    has_space = cnt_q < CNT_FULL;
    rd_ok     = bus.rd_valid && has_space;
    wr_rdy    = in_idle && !(rd_ok && (prio_q == PRIO_RD));
    rd_rdy    = in_idle && has_space && !(bus.wr_valid && (prio_q == PRIO_WR));
    wr_hs     = bus.wr_valid && wr_rdy;
    rd_hs     = bus.rd_valid && rd_rdy;
    req_addr  = wr_hs ? bus.wr_addr : bus.rd_addr;
    illegal   = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
  end

  // Access FSM, request capture, priority rotation and sticky error flag.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_clr ? 1'b0 : err_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_hs || rd_hs) begin
          prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = wr_hs;
            addr_d  = req_addr;
            wdata_d = wr_hs ? bus.wr_data : '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_gnt) state_d = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.mem_rvalid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-return FIFO; rd_ready already guarantees space for every push.
  always_comb begin
    pop    = (cnt_q != '0) && bus.rdata_ready;
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wptr_q] = bus.mem_rdata;
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Output drive; memory port fields are zero whenever no request is up.
  always_comb begin
    bus.wr_ready    = wr_rdy;
    bus.rd_ready    = rd_rdy;
    bus.mem_req     = (state_q == ISSUE);
    bus.mem_we      = (state_q == ISSUE) && we_q;
    bus.mem_addr    = (state_q == ISSUE) ? addr_q : '0;
    bus.mem_wdata   = (state_q == ISSUE) ? wdata_q : '0;
    bus.rdata_valid = (cnt_q != '0);
    bus.rdata       = fifo_q[rptr_q];
    err_addr        = err_q;
  end

  // State registers; reset abandons any access and flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= PRIO_WR;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter: inputs driven on the falling edge,
// outputs sampled 1ns later.
module tb_frame_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic err_addr;
  int   checks = 0;
  int   passed = 0;
  int   acc, target;
  logic [31:0] rd_base, last_addr;

  frame_mem_arbiter_if bus();

  frame_mem_arbiter #(
    .FRAME_SIZE_BYTES(3_686_400),
    .NUM_BUFS(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_clr(err_clr),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 0; bus.rd_addr = '0; bus.rdata_ready = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    err_clr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // One cycle of a read client issuing reads at rd_base+4*n and a memory
  // that answers each read with (address ^ 0xD000_0000).
  task automatic cycle_rd(input logic pop_en);
    @(negedge clk);
    bus.rd_addr     = rd_base + 32'(acc) * 4;
    bus.rd_valid    = (acc < target);
    bus.rdata_ready = pop_en;
    bus.mem_rdata   = last_addr ^ 32'hD000_0000;
    #1;
    if (bus.mem_req) last_addr = bus.mem_addr;
    if (bus.rd_valid && bus.rd_ready) acc++;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.wr_valid = 1; bus.rd_valid = 1; bus.mem_rvalid = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready, bus.mem_req, bus.mem_we, bus.rdata_valid, err_addr} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.wr_ready, bus.rd_ready, bus.mem_req, bus.mem_we, bus.rdata_valid, err_addr});
    else passed++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 96'h0)
      $display("FAIL reset_buses: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.rdata});
    else passed++;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b11)
      $display("FAIL reset_release_ready: got %b expected 11", {bus.wr_ready, bus.rd_ready});
    else passed++;
  endtask

  task automatic test_write();
    do_reset();
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 32'h10; bus.wr_data = 32'hA5A5_A5A5; bus.mem_gnt = 1;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1) $display("FAIL wr_accept: got %b expected 1", bus.wr_ready);
    else passed++;
    @(negedge clk);
    bus.wr_valid = 0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wr_ready} !== {2'b11, 32'h10, 32'hA5A5_A5A5, 1'b0})
      $display("FAIL wr_issue: got %b %b %h %h %b expected 1 1 00000010 a5a5a5a5 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wr_ready);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.mem_req, bus.wr_ready} !== 2'b01)
      $display("FAIL wr_done: got req=%b ready=%b expected req=0 ready=1", bus.mem_req, bus.wr_ready);
    else passed++;
    bus.mem_gnt = 0;
  endtask

  task automatic test_read_stall();
    do_reset();
    @(negedge clk);
    bus.rd_valid = 1; bus.rd_addr = 32'h0038_4000;
    #1;
    checks++;
    if (bus.rd_ready !== 1'b1) $display("FAIL rd_accept: got %b expected 1", bus.rd_ready);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.rd_valid = 0;
      bus.mem_gnt = (i == 3);
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b10, 32'h0038_4000, 32'h0})
        $display("FAIL rd_stall_%0d: got req=%b we=%b addr=%h wdata=%h expected 1 0 00384000 0",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      else passed++;
    end
    @(negedge clk);
    bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({bus.mem_req, bus.rdata_valid} !== 2'b00)
      $display("FAIL rd_wait: got req=%b rvalid=%b expected 0 0", bus.mem_req, bus.rdata_valid);
    else passed++;
    @(negedge clk);
    bus.mem_rvalid = 0;
    #1;
    checks++;
    if ({bus.rdata_valid, bus.rdata} !== {1'b1, 32'h1234_5678})
      $display("FAIL rd_data: got %b %h expected 1 12345678", bus.rdata_valid, bus.rdata);
    else passed++;
    bus.rdata_ready = 1;
    @(negedge clk);
    bus.rdata_ready = 0;
    #1;
    checks++;
    if (bus.rdata_valid !== 1'b0) $display("FAIL rd_pop_empty: got %b expected 0", bus.rdata_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic        we_log [4];
    logic [31:0] addr_log [4];
    logic [3:0]  exp_we;
    int          n;
    exp_we = 4'b0101;
    n = 0;
    do_reset();
    @(negedge clk);
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.rdata_ready = 1;
    bus.wr_valid = 1; bus.wr_addr = 32'h100; bus.wr_data = 32'h11;
    bus.rd_valid = 1; bus.rd_addr = 32'h200;
    #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b10)
      $display("FAIL arb_first: got %b expected 10", {bus.wr_ready, bus.rd_ready});
    else passed++;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_req) begin
        we_log[n] = bus.mem_we;
        addr_log[n] = bus.mem_addr;
        n++;
      end
    end
    checks++;
    if (n !== 4) $display("FAIL arb_count: got %0d expected 4", n);
    else passed++;
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({we_log[i], addr_log[i]} !== {exp_we[i], ((i % 2) == 0) ? 32'h100 : 32'h200})
        $display("FAIL arb_order_%0d: got we=%b addr=%h expected we=%b", i, we_log[i], addr_log[i], exp_we[i]);
      else passed++;
    end
    clear_inputs();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fifo_full();
    do_reset();
    bus.mem_gnt = 1; bus.mem_rvalid = 1;
    acc = 0; target = 5; rd_base = 32'h1000; last_addr = '0;
    repeat (30) cycle_rd(1'b0);
    checks++;
    if (acc !== 4) $display("FAIL full_accepted: got %0d expected 4", acc);
    else passed++;
    checks++;
    if ({bus.rd_ready, bus.rdata_valid, bus.rdata} !== {2'b01, 32'hD000_1000})
      $display("FAIL full_state: got ready=%b valid=%b data=%h expected 0 1 d0001000",
               bus.rd_ready, bus.rdata_valid, bus.rdata);
    else passed++;
    cycle_rd(1'b1);
    repeat (10) cycle_rd(1'b0);
    checks++;
    if (acc !== 5) $display("FAIL full_fifth: got %0d expected 5", acc);
    else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.rdata_ready = 1;
      #1;
      checks++;
      if ({bus.rdata_valid, bus.rdata} !== {1'b1, 32'hD000_1000 + 32'(k) * 4})
        $display("FAIL full_order_%0d: got %b %h expected 1 %h", k, bus.rdata_valid, bus.rdata,
                 32'hD000_1000 + 32'(k) * 4);
      else passed++;
    end
    @(negedge clk);
    bus.rdata_ready = 0;
    #1;
    checks++;
    if (bus.rdata_valid !== 1'b0) $display("FAIL full_drained: got %b expected 0", bus.rdata_valid);
    else passed++;
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 32'h00E1_0000; bus.mem_gnt = 1;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1) $display("FAIL ill_wr_ready: got %b expected 1", bus.wr_ready);
    else passed++;
    @(negedge clk);
    bus.wr_valid = 0; bus.rd_valid = 1; bus.rd_addr = 32'h2;
    #1;
    checks++;
    if ({bus.mem_req, err_addr, bus.rd_ready} !== 3'b011)
      $display("FAIL ill_wr_drop: got req=%b err=%b rd_ready=%b expected 0 1 1", bus.mem_req, err_addr, bus.rd_ready);
    else passed++;
    @(negedge clk);
    bus.rd_valid = 0;
    bus.wr_valid = 1; bus.wr_addr = 32'h3; err_clr = 1;
    #1;
    checks++;
    if ({bus.mem_req, err_addr} !== 2'b01)
      $display("FAIL ill_rd_drop: got req=%b err=%b expected 0 1", bus.mem_req, err_addr);
    else passed++;
    @(negedge clk);
    bus.wr_valid = 0; err_clr = 0;
    #1;
    checks++;
    if ({bus.mem_req, err_addr} !== 2'b01)
      $display("FAIL ill_set_wins: got req=%b err=%b expected 0 1", bus.mem_req, err_addr);
    else passed++;
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    #1;
    checks++;
    if (err_addr !== 1'b0) $display("FAIL ill_clear: got %b expected 0", err_addr);
    else passed++;
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 32'h00E0_FFFC; bus.wr_data = 32'h5;
    @(negedge clk);
    bus.wr_valid = 0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr, err_addr} !== {1'b1, 32'h00E0_FFFC, 1'b0})
      $display("FAIL ill_top_legal: got req=%b addr=%h err=%b expected 1 00e0fffc 0", bus.mem_req, bus.mem_addr, err_addr);
    else passed++;
    repeat (2) @(negedge clk);
    bus.mem_gnt = 0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.mem_gnt = 1; bus.mem_rvalid = 1;
    acc = 0; target = 2; rd_base = 32'h3000; last_addr = '0;
    repeat (12) cycle_rd(1'b0);
    checks++;
    if ({acc == 2, bus.rdata_valid} !== 2'b11)
      $display("FAIL mid_queued: got acc=%0d valid=%b expected 2 1", acc, bus.rdata_valid);
    else passed++;
    @(negedge clk);
    bus.mem_rvalid = 0; bus.rd_valid = 1; bus.rd_addr = 32'h2000;
    @(negedge clk);
    bus.rd_valid = 0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h2000})
      $display("FAIL mid_issue: got req=%b addr=%h expected 1 00002000", bus.mem_req, bus.mem_addr);
    else passed++;
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({bus.rdata_valid, bus.mem_req, bus.rd_ready} !== 3'b000)
      $display("FAIL mid_in_reset: got %b expected 000", {bus.rdata_valid, bus.mem_req, bus.rd_ready});
    else passed++;
    @(negedge clk);
    rst_n = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.rdata_valid, bus.rd_ready} !== 2'b01)
      $display("FAIL mid_after: got valid=%b rd_ready=%b expected 0 1", bus.rdata_valid, bus.rd_ready);
    else passed++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write();
    test_read_stall();
    test_back_to_back();
    test_fifo_full();
    test_illegal();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/frame_mem_arbiter.md
FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 Parameter FRAME_SIZE_BYTES, default 3_686_400, is the byte size of one frame buffer.
REQ-002 Parameter NUM_BUFS, default 4, is the number of frame buffers in memory.
REQ-003 Parameter FIFO_DEPTH, default 4, is the read-return FIFO depth in 32-bit words.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 wr_valid  in  1  write request from the pixel writer.
REQ-007 wr_addr  in  32  byte address of the write.
REQ-008 wr_data  in  32  write data word.
REQ-009 wr_ready  out  1  write request accepted when wr_valid && wr_ready.
REQ-010 rd_valid  in  1  read request from the frame reader.
REQ-011 rd_addr  in  32  byte address of the read.
REQ-012 rd_ready  out  1  read request accepted when rd_valid && rd_ready.
REQ-013 rdata_valid  out  1  read-return FIFO not empty.
REQ-014 rdata  out  32  read-return FIFO head word.
REQ-015 rdata_ready  in  1  consumer pops the head when rdata_valid && rdata_ready.
REQ-016 mem_req  out  1  memory access request.
REQ-017 mem_we  out  1  1 = write access, 0 = read access.
REQ-018 mem_addr  out  32  memory byte address.
REQ-019 mem_wdata  out  32  memory write data.
REQ-020 mem_gnt  in  1  memory accepts the access in a cycle where mem_req is 1.
REQ-021 mem_rvalid  in  1  memory read data valid.
REQ-022 mem_rdata  in  32  memory read data.
REQ-023 err_addr  out  1  sticky flag for an illegal address.
REQ-024 err_clr  in  1  clears err_addr.

Function
REQ-025 FSM states: IDLE, ISSUE, WAIT_RD. At most one memory access is outstanding at a time.
REQ-026 wr_ready is 1 only in IDLE.
REQ-027 rd_ready is 1 only in IDLE and only when FIFO count < FIFO_DEPTH.
REQ-028 Arbitration in IDLE when both requests are ready and valid:
- Round-robin; a priority bit selects the winner.
- The priority bit toggles after every accepted request.
- The losing request sees ready = 0 that cycle.
REQ-029 On acceptance, the address, data and type are registered, and the FSM moves to ISSUE on the next cycle.
REQ-030 Illegal address: addr[1:0] != 0 or addr >= NUM_BUFS*FRAME_SIZE_BYTES (unsigned, 32-bit compare).
- The request is dropped; the FSM stays in IDLE.
- err_addr is set the next cycle.
- No memory access occurs and no rdata is produced.
REQ-031 ISSUE: mem_req = 1, with mem_we, mem_addr and mem_wdata held stable until mem_gnt.
- Write on mem_gnt: go to IDLE.
- Read on mem_gnt: go to WAIT_RD.
REQ-032 WAIT_RD: on mem_rvalid, push mem_rdata into the FIFO and go to IDLE. mem_rvalid in any other state is ignored.
REQ-033 mem_wdata is 0 for reads. mem_req is 0 outside ISSUE.
REQ-034 Minimum latency, with mem_gnt and mem_rvalid at the earliest cycles:
- Read accepted at cycle T: mem_req at T+1, WAIT_RD at T+2, mem_rvalid at T+2, rdata_valid at T+3.
- Write accepted at T: mem_req at T+1, back in IDLE at T+2.
REQ-035 The FIFO is first-in first-out; rdata is the registered head.
- Push and pop in the same cycle leave the count unchanged.
- The FIFO never overflows, guaranteed by REQ-027.
- A pop when empty has no effect.
REQ-036 err_addr set takes priority over err_clr in the same cycle.

Reset
REQ-037 While rst_n = 0:
- FSM = IDLE, FIFO empty, priority = write.
- All outputs are 0, including wr_ready and rd_ready.
REQ-038 Reset mid-operation abandons any outstanding access and flushes the FIFO. A mem_rvalid after reset release is ignored.

Verification
REQ-039 Write wr_addr = 0x0000_0010, wr_data = 0xA5A5_A5A5, mem_gnt held 1 -> one cycle of mem_req = 1, mem_we = 1, mem_addr = 0x10, mem_wdata = 0xA5A5_A5A5; wr_ready = 1 again 2 cycles after acceptance.
REQ-040 Read rd_addr = 0x0038_4000 with mem_gnt delayed 3 cycles, then mem_rvalid with 0x1234_5678 -> mem_addr stable during the stall; rdata = 0x1234_5678 and rdata_valid = 1 one cycle after mem_rvalid.
REQ-041 wr_valid and rd_valid held 1 for 4 accesses -> memory order write, read, write, read.
REQ-042 rdata_ready = 0 and 5 reads requested -> 4 words are queued and rd_ready stays 0; one pop -> the 5th read is accepted; data is returned in request order.
REQ-043 wr_addr = 0x00E1_0000 (= 4*FRAME_SIZE_BYTES), then rd_addr = 0x2 -> no mem_req and err_addr = 1; err_clr together with a new illegal request -> err_addr stays 1; err_clr alone -> err_addr = 0.
REQ-044 rst_n asserted in WAIT_RD with 2 words queued, then mem_rvalid = 1 after release -> rdata_valid = 0 and the FIFO stays empty.
